// File: rtl/uart_rx_pkg.sv
// Shared types and defaults for the UART receive sequencer.
// Check point helper: the oversampled bit is stable two edges past mid-bit.
package uart_rx_pkg;

   localparam int DATA_WIDTH_DEF = 8;
   localparam int PRESCALE_W_DEF = 6;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } rx_state_e;

   function automatic int unsigned check_edge(input int unsigned pre);
      return pre / 2 + 2;
   endfunction

endpackage

// File: rtl/uart_edge_bit_counter.sv
// Oversample edge counter and payload bit counter for the UART receiver.
// Edge count wraps at pre_q-1 (bit end); restart loads edge 1 for a start edge seen this cycle.
module uart_edge_bit_counter
   import uart_rx_pkg::*;
#(
   parameter int PRESCALE_W = PRESCALE_W_DEF,
   parameter int BIT_W      = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cnt_en,
   input  logic                  cnt_restart,
   input  logic                  bit_cnt_en,
   input  logic                  bit_cnt_clr,
   input  logic [PRESCALE_W-1:0] pre_q,
   output logic [PRESCALE_W-1:0] edge_cnt,
   output logic [BIT_W-1:0]      bit_cnt,
   output logic                  bit_end
);

   logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
   logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;

   always_comb begin
      bit_end    = cnt_en && (edge_cnt_q == (pre_q - PRESCALE_W'(1)));
      edge_cnt_d = '0;
      bit_cnt_d  = bit_cnt_q;

      // The cycle that sees the start edge is edge 0, so the next one is edge 1.
      if (cnt_restart) begin
         edge_cnt_d = PRESCALE_W'(1);
      end else if (cnt_en) begin
         edge_cnt_d = bit_end ? '0 : edge_cnt_q + PRESCALE_W'(1);
      end

      if (bit_cnt_clr) begin
         bit_cnt_d = '0;
      end else if (bit_cnt_en && bit_end) begin
         bit_cnt_d = bit_cnt_q + BIT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         edge_cnt_q <= '0;
         bit_cnt_q  <= '0;
      end else begin
         edge_cnt_q <= edge_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
      end
   end

   assign edge_cnt = edge_cnt_q;
   assign bit_cnt  = bit_cnt_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start detect, per-bit checker enables, frame verdict.
// Enables land on the check edge of each bit; data_valid/frame_err one cycle after stop bit end.
module uart_rx_ctrl
   import uart_rx_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int PRESCALE_W = PRESCALE_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx_in,
   input  logic                  par_en,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic                  start_error,
   input  logic                  parity_error,
   input  logic                  stop_error,
   output logic [PRESCALE_W-1:0] edge_cnt,
   output logic                  dat_samp_en,
   output logic                  start_check_en,
   output logic                  deser_en,
   output logic                  parity_check_en,
   output logic                  stop_check_en,
   output logic                  data_valid,
   output logic                  frame_err,
   output logic                  busy
);

   localparam int BIT_W = $clog2(DATA_WIDTH) + 1;

   rx_state_e             state_q, state_d;
   logic [PRESCALE_W-1:0] pre_q, pre_d;
   logic                  par_q, par_d;
   logic                  perr_q, perr_d;

   logic dat_samp_en_q, dat_samp_en_d;
   logic start_check_en_q, start_check_en_d;
   logic deser_en_q, deser_en_d;
   logic parity_check_en_q, parity_check_en_d;
   logic stop_check_en_q, stop_check_en_d;
   logic data_valid_q, data_valid_d;
   logic frame_err_q, frame_err_d;

   logic                  cnt_restart;
   logic                  bit_cnt_clr;
   logic                  bit_end;
   logic                  bad;
   logic [BIT_W-1:0]      bit_cnt;
   logic [PRESCALE_W-1:0] pre_chk;
   logic                  at_pre_chk;

   // Enables are registered, so they are decided one edge before the check point.
   assign pre_chk    = PRESCALE_W'(check_edge(32'(pre_q)) - 32'd1);
   assign at_pre_chk = (edge_cnt == pre_chk);

   uart_edge_bit_counter #(
      .PRESCALE_W (PRESCALE_W),
      .BIT_W      (BIT_W)
   ) u_cnt (
      .clk         (clk),
      .rst         (rst),
      .cnt_en      (state_q != IDLE),
      .cnt_restart (cnt_restart),
      .bit_cnt_en  (state_q == DATA),
      .bit_cnt_clr (bit_cnt_clr),
      .pre_q       (pre_q),
      .edge_cnt    (edge_cnt),
      .bit_cnt     (bit_cnt),
      .bit_end     (bit_end)
   );

   always_comb begin
      state_d           = state_q;
      pre_d             = pre_q;
      par_d             = par_q;
      perr_d            = perr_q;
      cnt_restart       = 1'b0;
      bit_cnt_clr       = (state_q == START);
      bad               = 1'b0;
      start_check_en_d  = 1'b0;
      deser_en_d        = 1'b0;
      parity_check_en_d = 1'b0;
      stop_check_en_d   = 1'b0;
      data_valid_d      = 1'b0;
      frame_err_d       = 1'b0;

      case (state_q)
         IDLE: begin
            if (!rx_in) begin
               state_d     = START;
               pre_d       = prescale;
               par_d       = par_en;
               perr_d      = 1'b0;
               cnt_restart = 1'b1;
            end
         end
         START: begin
            start_check_en_d = at_pre_chk;
            if (bit_end) begin
               if (start_error) begin
                  state_d     = IDLE;
                  frame_err_d = 1'b1;
               end else begin
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            deser_en_d = at_pre_chk;
            if (bit_end && (bit_cnt == BIT_W'(DATA_WIDTH - 1))) begin
               state_d = par_q ? PARITY : STOP;
            end
         end
         PARITY: begin
            parity_check_en_d = at_pre_chk;
            if (bit_end) begin
               perr_d  = parity_error;
               state_d = STOP;
            end
         end
         STOP: begin
            stop_check_en_d = at_pre_chk;
            if (bit_end) begin
               bad          = stop_error | perr_q;
               data_valid_d = !bad;
               frame_err_d  = bad;
               // A low line on the stop bit end is already the next start edge.
               if (!rx_in) begin
                  state_d     = START;
                  perr_d      = 1'b0;
                  cnt_restart = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      dat_samp_en_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q           <= IDLE;
         pre_q             <= '0;
         par_q             <= 1'b0;
         perr_q            <= 1'b0;
         dat_samp_en_q     <= 1'b0;
         start_check_en_q  <= 1'b0;
         deser_en_q        <= 1'b0;
         parity_check_en_q <= 1'b0;
         stop_check_en_q   <= 1'b0;
         data_valid_q      <= 1'b0;
         frame_err_q       <= 1'b0;
      end else begin
         state_q           <= state_d;
         pre_q             <= pre_d;
         par_q             <= par_d;
         perr_q            <= perr_d;
         dat_samp_en_q     <= dat_samp_en_d;
         start_check_en_q  <= start_check_en_d;
         deser_en_q        <= deser_en_d;
         parity_check_en_q <= parity_check_en_d;
         stop_check_en_q   <= stop_check_en_d;
         data_valid_q      <= data_valid_d;
         frame_err_q       <= frame_err_d;
      end
   end

   assign dat_samp_en     = dat_samp_en_q;
   assign start_check_en  = start_check_en_q;
   assign deser_en        = deser_en_q;
   assign parity_check_en = parity_check_en_q;
   assign stop_check_en   = stop_check_en_q;
   assign data_valid      = data_valid_q;
   assign frame_err       = frame_err_q;
   assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: frames planned on a cycle timeline from bit-period arithmetic,
// then every output of every cycle is compared against that timeline.
module tb_uart_rx_ctrl;

   localparam int N = 9000;

   logic       clk = 1'b0;
   logic       rst, rx_in, par_en, start_error, parity_error, stop_error;
   logic [5:0] prescale;
   logic [5:0] edge_cnt;
   logic       dat_samp_en, start_check_en, deser_en, parity_check_en, stop_check_en;
   logic       data_valid, frame_err, busy;

   uart_rx_ctrl dut (
      .clk             (clk),
      .rst             (rst),
      .rx_in           (rx_in),
      .par_en          (par_en),
      .prescale        (prescale),
      .start_error     (start_error),
      .parity_error    (parity_error),
      .stop_error      (stop_error),
      .edge_cnt        (edge_cnt),
      .dat_samp_en     (dat_samp_en),
      .start_check_en  (start_check_en),
      .deser_en        (deser_en),
      .parity_check_en (parity_check_en),
      .stop_check_en   (stop_check_en),
      .data_valid      (data_valid),
      .frame_err       (frame_err),
      .busy            (busy)
   );

   always #5 clk = ~clk;

   // Stimulus per cycle (inputs sampled at the end of that cycle).
   bit         rx_a [N];
   bit         rst_a[N];
   bit         par_a[N];
   bit         se_a [N];
   bit         pe_a [N];
   bit         te_a [N];
   int         pre_a[N];
   // Expected outputs per cycle; en_e = {start, deser, parity, stop}.
   bit         busy_e[N];
   bit         dv_e  [N];
   bit         fe_e  [N];
   logic [3:0] en_e  [N];
   logic [5:0] edge_e[N];
   // Observed vector {busy, samp, start, deser, par, stop, dv, fe, edge[5:0]}.
   logic [13:0] obs_v[N];

   int checks   = 0;
   int failures = 0;
   int t0s[8];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int pick_pre();
      case ($urandom_range(0, 2))
         0:       return 8;
         1:       return 16;
         default: return 32;
      endcase
   endfunction

   task automatic set_en(input int c, input int k, input int lim);
      if (c <= lim && c < N) en_e[c][k] = 1'b1;
   endtask

   function automatic int win_sum(input int lo, input int hi, input int pos);
      int s = 0;
      for (int c = lo + 1; c <= hi && c < N; c++) s += int'(obs_v[c][pos]);
      return s;
   endfunction

   // One frame starting (line low) at cycle t0. Bit k spans [t0+k*pp, t0+(k+1)*pp).
   task automatic plan_frame(input int t0, input int pp, input bit p, input bit sb,
                             input bit pb, input bit tbad, input int rst_at,
                             input logic [7:0] d, output int nxt, output int e_cyc,
                             output bit clean);
      int  ck, nbits, e, lim;
      bit  v, bad;
      ck    = pp / 2 + 2;
      nbits = sb ? 1 : 10 + int'(p);
      e     = t0 + nbits * pp - 1;
      lim   = (rst_at > 0) ? rst_at : e + 1;
      pre_a[t0] = pp;
      par_a[t0] = p;
      if (sb) begin
         for (int c = t0; c < t0 + 3; c++) rx_a[c] = 1'b0;
      end else begin
         for (int b = 0; b < nbits; b++) begin
            if (b == 0)            v = 1'b0;
            else if (b <= 8)       v = d[b-1];
            else if (b == 9 && p)  v = ^d;
            else                   v = 1'b1;
            for (int c = t0 + b * pp; c < t0 + (b + 1) * pp && c <= lim; c++) rx_a[c] = v;
         end
      end
      for (int c = t0 + 1; c <= e && c <= lim; c++) begin
         busy_e[c] = 1'b1;
         edge_e[c] = 6'((c - t0) % pp);
      end
      set_en(t0 + ck, 3, lim);
      if (!sb) begin
         for (int i = 0; i < 8; i++) set_en(t0 + (1 + i) * pp + ck, 2, lim);
         if (p) set_en(t0 + 9 * pp + ck, 1, lim);
         set_en(t0 + (9 + int'(p)) * pp + ck, 0, lim);
      end
      bad = (p && pb) || tbad;
      if (e + 1 <= lim) begin
         if (sb || bad) fe_e[e+1] = 1'b1;
         else           dv_e[e+1] = 1'b1;
      end
      // Flags hold the verdict from just after the check point to the bit end;
      // outside those windows they carry random noise that must be ignored.
      for (int c = t0 + ck + 1; c < t0 + pp; c++) se_a[c] = sb;
      if (!sb && p)
         for (int c = t0 + 9 * pp + ck + 1; c < t0 + 10 * pp; c++) pe_a[c] = pb;
      if (!sb)
         for (int c = t0 + (9 + int'(p)) * pp + ck + 1; c <= e; c++) te_a[c] = tbad;
      if (rst_at > 0) begin
         rst_a[rst_at] = 1'b1;
         nxt   = rst_at + 1;
         clean = 1'b0;
      end else begin
         nxt   = e + 1;
         clean = !sb;
      end
      e_cyc = e;
   endtask

   initial begin
      int   t0, nxt, e_prev, fi, pp, rst_at;
      bit   p, sb, pb, tbad, btb, prev_clean, want_rst;
      logic [7:0] d;
      logic [13:0] exp_v;

      for (int c = 0; c < N; c++) begin
         rx_a[c]   = 1'b1;
         rst_a[c]  = (c < 5);
         par_a[c]  = 1'($urandom_range(0, 1));
         pre_a[c]  = pick_pre();
         se_a[c]   = 1'($urandom_range(0, 1));
         pe_a[c]   = 1'($urandom_range(0, 1));
         te_a[c]   = 1'($urandom_range(0, 1));
         busy_e[c] = 1'b0;
         dv_e[c]   = 1'b0;
         fe_e[c]   = 1'b0;
         en_e[c]   = 4'h0;
         edge_e[c] = 6'd0;
         obs_v[c]  = '0;
      end

      nxt = 8; e_prev = 0; fi = 0; prev_clean = 1'b0; pp = 8; p = 1'b0;
      while (nxt + 400 < N) begin
         btb = 1'b0; want_rst = 1'b0; sb = 1'b0; pb = 1'b0; tbad = 1'b0;
         d = 8'($urandom);
         case (fi)
            0: begin pp = 8;  p = 1'b0; d = 8'hA5; end
            1: begin pp = 16; p = 1'b0; sb = 1'b1; end
            2: begin pp = 8;  p = 1'b1; pb = 1'b1; end
            3: begin pp = 32; p = 1'b0; tbad = 1'b1; end
            4: begin pp = 8;  p = 1'b0; end
            5: btb = 1'b1;
            6: begin pp = 8;  p = 1'b0; want_rst = 1'b1; end
            7: begin pp = 8;  p = 1'b0; end
            default: begin
               btb = prev_clean && ($urandom_range(0, 3) == 0);
               if (!btb) begin
                  pp = pick_pre();
                  p  = 1'($urandom_range(0, 1));
               end
               sb       = ($urandom_range(0, 5) == 0);
               pb       = ($urandom_range(0, 3) == 0);
               tbad     = ($urandom_range(0, 3) == 0);
               want_rst = !sb && ($urandom_range(0, 9) == 0);
            end
         endcase
         if (btb)          t0 = e_prev;
         else if (fi == 0) t0 = nxt;
         else              t0 = nxt + ((fi < 8) ? 2 : int'($urandom_range(0, 4)));
         rst_at = want_rst ? t0 + 4 * pp + int'($urandom_range(0, pp - 1)) : 0;
         if (fi < 8) t0s[fi] = t0;
         plan_frame(t0, pp, p, sb, pb, tbad, rst_at, d, nxt, e_prev, prev_clean);
         fi++;
      end

      for (int c = 0; c < N - 1; c++) begin
         rst          = rst_a[c];
         rx_in        = rx_a[c];
         prescale     = 6'(pre_a[c]);
         par_en       = par_a[c];
         start_error  = se_a[c];
         parity_error = pe_a[c];
         stop_error   = te_a[c];
         @(posedge clk);
         #1;
         obs_v[c+1] = {busy, dat_samp_en, start_check_en, deser_en, parity_check_en,
                       stop_check_en, data_valid, frame_err, edge_cnt};
         exp_v      = {busy_e[c+1], busy_e[c+1], en_e[c+1], dv_e[c+1], fe_e[c+1], edge_e[c+1]};
         check_eq($sformatf("cyc%0d", c + 1), 32'(obs_v[c+1]), 32'(exp_v));
      end

      // Frame-level properties of the directed frames.
      check_eq("clean_deser_cnt", 32'(win_sum(t0s[0], t0s[0] + 81, 10)), 32'd8);
      check_eq("clean_dv_at_80",  32'(obs_v[t0s[0] + 80][7]), 32'd1);
      check_eq("clean_dv_cnt",    32'(win_sum(t0s[0], t0s[0] + 81, 7)), 32'd1);
      check_eq("clean_fe_cnt",    32'(win_sum(t0s[0], t0s[0] + 81, 6)), 32'd0);
      check_eq("glitch_deser",    32'(win_sum(t0s[1], t0s[1] + 17, 10)), 32'd0);
      check_eq("glitch_fe_cnt",   32'(win_sum(t0s[1], t0s[1] + 17, 6)), 32'd1);
      check_eq("glitch_idle",     32'(obs_v[t0s[1] + 16][13]), 32'd0);
      check_eq("par_chk_bit9",    32'(obs_v[t0s[2] + 78][9]), 32'd1);
      check_eq("par_fe_cnt",      32'(win_sum(t0s[2], t0s[2] + 89, 6)), 32'd1);
      check_eq("par_dv_cnt",      32'(win_sum(t0s[2], t0s[2] + 89, 7)), 32'd0);
      check_eq("stop_fe_cnt",     32'(win_sum(t0s[3], t0s[3] + 321, 6)), 32'd1);
      check_eq("stop_dv_cnt",     32'(win_sum(t0s[3], t0s[3] + 321, 7)), 32'd0);
      check_eq("stop_idle",       32'(obs_v[t0s[3] + 320][13]), 32'd0);
      check_eq("b2b_dv1",         32'(obs_v[t0s[4] + 80][7]), 32'd1);
      check_eq("b2b_dv2",         32'(obs_v[t0s[4] + 159][7]), 32'd1);
      check_eq("b2b_start_edge1", 32'(obs_v[t0s[4] + 80][5:0]), 32'd1);
      check_eq("post_rst_dv",     32'(obs_v[t0s[7] + 80][7]), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
